// File: rtl/inputc_mvc.sv
// Multi-VC router input channel: per-VC flit FIFOs, XY routing, wormhole lock
// and a round-robin VC selector feeding one switch request per cycle.
//
// state  | meaning
// IDLE   | no route held; a head at the front is routed, a stray body/tail is dropped
// ACTIVE | route latched in port_r; flits leave on grant until a tail is sent
module inputc_mvc #(
    parameter int NVC      = 2,
    parameter int DEPTH    = 4,
    parameter int DATAW    = 32,
    parameter int XW       = 4,
    parameter int YW       = 4,
    parameter int MY_XPOS  = 0,
    parameter int MY_YPOS  = 0,
    localparam int VW      = (NVC > 1) ? $clog2(NVC) : 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic [VW-1:0]    ivch,
    output logic [NVC-1:0]   ordy,
    output logic [NVC-1:0]   oack,
    output logic [NVC-1:0]   olck,
    input  logic [5*NVC-1:0] irdy,
    output logic             req,
    output logic [2:0]       port,
    output logic [VW-1:0]    ovch,
    input  logic             grt,
    output logic [DATAW-1:0] odata,
    output logic             ovalid,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_N     = 3'd1;
    localparam logic [2:0] P_E     = 3'd2;
    localparam logic [2:0] P_S     = 3'd3;
    localparam logic [2:0] P_W     = 3'd4;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} vc_state_t;

    logic [DATAW-1:0] mem [NVC][DEPTH];
    logic [AW-1:0]    wr_ptr [NVC];
    logic [AW-1:0]    rd_ptr [NVC];
    logic [CW-1:0]    count [NVC];
    vc_state_t        state [NVC];
    vc_state_t        state_nxt [NVC];
    logic [2:0]       port_r [NVC];
    logic [2:0]       port_nxt [NVC];
    logic [DATAW-1:0] front [NVC];
    logic [VW-1:0]    rr;
    logic [VW-1:0]    sel;
    logic [NVC-1:0]   push;
    logic [NVC-1:0]   pop;
    logic [NVC-1:0]   elig;
    logic [NVC-1:0]   bad_front;
    logic             send;
    logic             overflow;
    logic             bad_vch;

    function automatic logic [2:0] xy_route(input logic [XW-1:0] dx, input logic [YW-1:0] dy);
        if (int'(dx) > MY_XPOS)      return P_E;
        else if (int'(dx) < MY_XPOS) return P_W;
        else if (int'(dy) > MY_YPOS) return P_S;
        else if (int'(dy) < MY_YPOS) return P_N;
        else                         return P_LOCAL;
    endfunction

    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            front[v] = mem[v][rd_ptr[v]];
            olck[v]  = (state[v] == ACTIVE);
            ordy[v]  = (count[v] != CW'(DEPTH));
        end
    end

    // A write to a full VC is dropped; an out-of-range VC number is a protocol error.
    always_comb begin
        push     = '0;
        overflow = 1'b0;
        bad_vch  = 1'b0;
        if (ivalid) begin
            if (int'(ivch) >= NVC)                bad_vch  = 1'b1;
            else if (count[ivch] == CW'(DEPTH))   overflow = 1'b1;
            else                                  push[ivch] = 1'b1;
        end
    end

    always_comb begin
        elig      = '0;
        bad_front = '0;
        for (int v = 0; v < NVC; v++) begin
            state_nxt[v] = state[v];
            port_nxt[v]  = port_r[v];
            case (state[v])
                IDLE: begin
                    if (count[v] != '0) begin
                        if (front[v][DATAW-2]) begin
                            port_nxt[v]  = xy_route(front[v][XW-1:0], front[v][XW+YW-1:XW]);
                            state_nxt[v] = ACTIVE;
                        end else begin
                            bad_front[v] = 1'b1;
                        end
                    end
                end
                ACTIVE: elig[v] = (count[v] != '0) && irdy[int'(port_r[v]) * NVC + v];
                default: state_nxt[v] = IDLE;
            endcase
        end

        req = 1'b0;
        sel = '0;
        for (int k = 0; k < NVC; k++) begin
            if (!req && elig[(int'(rr) + k) % NVC]) begin
                req = 1'b1;
                sel = VW'((int'(rr) + k) % NVC);
            end
        end

        send   = req & grt;
        port   = req ? port_r[sel] : 3'd0;
        ovch   = req ? sel : '0;
        ovalid = send;
        odata  = send ? front[sel] : '0;
        pop    = bad_front;
        if (send) begin
            pop[sel] = 1'b1;
            if (front[sel][DATAW-1]) state_nxt[sel] = IDLE;
        end
        oack = pop;
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int v = 0; v < NVC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
                state[v]  <= IDLE;
                port_r[v] <= P_LOCAL;
            end
            rr  <= '0;
            err <= 1'b0;
        end else begin
            for (int v = 0; v < NVC; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
                case ({push[v], pop[v]})
                    2'b10:   count[v] <= count[v] + 1'b1;
                    2'b01:   count[v] <= count[v] - 1'b1;
                    default: count[v] <= count[v];
                endcase
                state[v]  <= state_nxt[v];
                port_r[v] <= port_nxt[v];
            end
            if (send) rr <= (int'(sel) == NVC - 1) ? '0 : sel + 1'b1;
            if (overflow || bad_vch || (|bad_front)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NVC; v++) begin
            if (push[v]) mem[v][wr_ptr[v]] <= idata;
        end
    end

endmodule

// File: doc/inputc_mvc.md
Name: inputc_mvc

Overview:
Parametrised multi-VC router input channel, the successor to the single-VC input channel. It provides NVC independent flit FIFOs of depth DEPTH, per-VC XY route computation and a per-VC wormhole lock. A round-robin VC selector presents one switch request per cycle to the crossbar allocator. It sits between the upstream link and the switch allocator/crossbar of one router physical channel.

Parameters:
NVC, 2, number of virtual channels (1..8)
DEPTH, 4, flits per VC FIFO (power of 2, >=2)
DATAW, 32, flit width in bits
XW, 4, destination X field width
YW, 4, destination Y field width
MY_XPOS, 0, router X coordinate
MY_YPOS, 0, router Y coordinate

Ports:
clk  in  1  clock
rst_  in  1  reset; synchronous, active-high (rst_=1 resets on clk rising edge)
idata  in  DATAW  incoming flit
ivalid  in  1  idata valid
ivch  in  clog2(NVC) (min 1)  VC of incoming flit
ordy  out  NVC  per-VC FIFO not full
oack  out  NVC  per-VC credit pulse, 1 cycle per flit popped
olck  out  NVC  VC holds a route (ACTIVE)
irdy  in  5*NVC  downstream VC ready, bit index port*NVC+vc
req  out  1  switch request from selected VC
port  out  3  requested output port: 0 local, 1 N, 2 E, 3 S, 4 W
ovch  out  clog2(NVC)  output VC (equals input VC)
grt  in  1  grant for the current req
odata  out  DATAW  flit sent
ovalid  out  1  odata valid
err  out  1  sticky protocol/overflow error

Behaviour:
- Flit type = idata[DATAW-1:DATAW-2]: 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL. Head dest X = [XW-1:0], dest Y = [XW+YW-1:XW].
- Reset: all FIFOs empty, all VCs IDLE, rr pointer 0. Outputs: ordy all 1 (combinational from count), all others 0.
- FIFO: write when ivalid and count[ivch]<DEPTH. Write to a full VC drops the flit and sets err. Simultaneous push/pop on one VC leaves count unchanged. No fall-through: a pushed flit is visible at the front the next cycle. Pointers wrap modulo DEPTH.
- Per-VC FSM:
  - IDLE: if non-empty and front is HEAD/HEADTAIL, latch XY route into port_r and go to ACTIVE. If front is BODY/TAIL, pop it, pulse oack, set err, stay IDLE.
  - ACTIVE: eligible when non-empty and irdy[port_r*NVC+vc]=1. On send of TAIL/HEADTAIL, return to IDLE. The next head may route on the following cycle, so the minimum head gap is 1 idle cycle.
- XY route: dx>MY_XPOS→E; dx<MY_XPOS→W; else dy>MY_YPOS→S; dy<MY_YPOS→N; else local.
- Selection (combinational): first eligible VC at or after rr pointer, cyclically. req=1 with port/ovch of that VC. With no eligible VC, req=0 and port=ovch=0.
- Send: when req&grt in the same cycle, odata=front flit, ovalid=1, pop, pulse oack[vc], and rr pointer ← sel+1 mod NVC. If grt=0, nothing pops and the pointer holds. When not sending, odata=0 and ovalid=0.
- olck[v]=1 exactly while VC v is ACTIVE.
- rst_ mid-packet: all state cleared, buffered flits discarded, err cleared.
- err is cleared only by reset.

Test Plan:
- Reset → ordy=2'b11, req=0, ovalid=0, oack=0, err=0, olck=0.
- MY=(1,1); HEADTAIL dest (3,1) on VC0, irdy all 1, grt=1 → req on cycle 2 with port=2, ovch=0; odata=flit, ovalid=1, oack[0] pulse; olck[0] high 1 cycle then 0.
- VC0 packet dest (0,1) and VC1 packet dest (1,0), both ACTIVE, grt held 1 → sends alternate VC0,VC1,VC0 with port 4 then 1; tails return both olck to 0.
- DEPTH=4: 5 writes to VC1, no grant → ordy[1]=0 after 4th write; 5th flit dropped, err=1; 4 grants pop exactly the 4 stored flits.
- VC0 ACTIVE port E, irdy[2*NVC+0]=0 → req=0 and no pop; irdy raised → req next evaluation, flit sent on grt.
- BODY flit at front of IDLE VC0 → popped, oack[0] pulse, err=1, no req; rst_=1 mid-packet → FIFOs empty and all outputs at reset values next cycle.
